alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec.sv | 150 +++++++++++++++
 tb/tb_alu_exec.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ADD/SUB/logic/SLT, iterative SLL and shift-add MUL.
// Handshake is start in IDLE, busy during iteration, one-cycle done when F/ZF/OF are new.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       ALU_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic             ZF,
  output logic             OF
);

  // state | meaning
  // IDLE  | waiting for start; single-cycle ops resolve on the accept edge
  // CALC  | iterating SLL (one bit per cycle) or MUL (one multiplier bit per cycle)
  // DONE  | one-cycle result pulse; start ignored
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  state_t           state;
  logic [CW-1:0]    count;
  logic             mul_mode;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] acc;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] quick_f;
  logic             quick_of;
  logic             iterative;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] acc_next;
  logic             last_iter;

  assign sum  = A + B;
  assign diff = A - B;

  always_comb begin
    quick_f  = '0;
    quick_of = 1'b0;
    case (ALU_op)
      OP_ADD: begin
        quick_f  = sum;
        quick_of = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        quick_f  = diff;
        quick_of = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: quick_f = A & B;
      OP_OR:  quick_f = A | B;
      OP_XOR: quick_f = A ^ B;
      OP_SLT: quick_f = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL: quick_f = A;  // only reached with a zero shift amount
      default: quick_f = '0;
    endcase
  end

  assign iterative  = (ALU_op == OP_MUL) || ((ALU_op == OP_SLL) && (B[4:0] != 5'd0));
  assign shift_next = shreg << 1;
  assign acc_next   = mplr[0] ? (acc + shreg) : acc;
  assign last_iter  = (count == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      F        <= '0;
      ZF       <= 1'b1;
      OF       <= 1'b0;
      count    <= '0;
      mul_mode <= 1'b0;
      shreg    <= '0;
      mplr     <= '0;
      acc      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (iterative) begin
              state    <= CALC;
              busy     <= 1'b1;
              mul_mode <= (ALU_op == OP_MUL);
              shreg    <= A;
              mplr     <= B;
              acc      <= '0;
              count    <= (ALU_op == OP_MUL) ? CW'(WIDTH) : CW'(B[4:0]);
            end else begin
              state <= DONE;
              done  <= 1'b1;
              F     <= quick_f;
              ZF    <= (quick_f == '0);
              OF    <= quick_of;
            end
          end
        end
        CALC: begin
          shreg <= shift_next;
          count <= count - CW'(1);
          if (mul_mode) begin
            acc  <= acc_next;
            mplr <= mplr >> 1;
          end
          if (last_iter) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            OF    <= 1'b0;
            if (mul_mode) begin
              F  <= acc_next;
              ZF <= (acc_next == '0);
            end else begin
              F  <= shift_next;
              ZF <= (shift_next == '0);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed-vector bench for alu_exec: stimulus pushes expected results into a
// queue, a negedge monitor pops and compares on every done pulse.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  ALU_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] F;
  logic        ZF;
  logic        OF;

  int n_total = 0;
  int n_pass  = 0;
  logic [33:0] exp_q[$];

  alu_exec #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALU_op(ALU_op), .A(A), .B(B),
    .busy(busy), .done(done), .F(F), .ZF(ZF), .OF(OF)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      logic [33:0] e;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_done: got F=0x%08h ZF=%0b OF=%0b want no done", F, ZF, OF);
      end else begin
        e = exp_q.pop_front();
        if ({F, ZF, OF} === e) n_pass++;
        else $display("FAIL result: got F=0x%08h ZF=%0b OF=%0b want F=0x%08h ZF=%0b OF=%0b",
                      F, ZF, OF, e[33:2], e[1], e[0]);
      end
    end
  end

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] ef, input logic eof,
                     input int lat, input bit noise);
    int n;
    int nb;
    bit seen;
    @(negedge clk);
    start = 1'b1; ALU_op = op; A = a; B = b;
    exp_q.push_back({ef, (ef == 32'd0), eof});
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; nb = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        start = 1'b0;
      end else begin
        if (busy) nb++;
        n++;
        if (noise) begin
          start  = 1'($urandom_range(0, 1));
          ALU_op = 3'($urandom_range(0, 7));
          A = $urandom; B = $urandom;
        end
      end
    end
    start = 1'b0;
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_latency"}, n, lat);
    check({name, "_busy_cycles"}, nb, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; ALU_op = 3'd0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_F", F, 32'd0);
    check("reset_flags", {29'd0, ZF, OF, busy}, {29'd0, 1'b1, 1'b0, 1'b0});
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    run("add_ovf",  3'b000, 32'h7FFF_FFFF, 32'd1,        32'h8000_0000, 1'b1, 0, 0);
    run("sub_zero", 3'b001, 32'd5,         32'd5,        32'd0,         1'b0, 0, 0);
    @(negedge clk);
    check("hold_F", F, 32'd0);
    check("hold_ZF", 32'(ZF), 32'd1);
    run("slt_neg",  3'b101, 32'hFFFF_FFFF, 32'd1,        32'd1,         1'b0, 0, 0);
    run("slt_pos",  3'b101, 32'd1,         32'hFFFF_FFFF, 32'd0,        1'b0, 0, 0);
    run("and",      3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 0, 0);
    run("or",       3'b011, 32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF, 1'b0, 0, 0);
    run("xor",      3'b100, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0, 0, 0);
    run("sub_ovf",  3'b001, 32'h8000_0000, 32'd1,        32'h7FFF_FFFF, 1'b1, 0, 0);
    run("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'd1,        32'd0,         1'b0, 0, 0);
    run("sll_4",    3'b110, 32'd1,         32'd4,        32'h0000_0010, 1'b0, 4, 0);
    run("sll_0",    3'b110, 32'hDEAD_BEEF, 32'd0,        32'hDEAD_BEEF, 1'b0, 0, 0);
    run("sll_hi",   3'b110, 32'h8000_0001, 32'h21,       32'h0000_0002, 1'b0, 1, 0);
    run("mul",      3'b111, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 1'b0, 32, 1);
    run("mul_wrap", 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        1'b0, 32, 0);

    // Reset in the middle of a MUL: no done, outputs back to reset values.
    @(negedge clk);
    start = 1'b1; ALU_op = 3'b111; A = 32'h1234; B = 32'h5678;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_F", F, 32'd0);
    check("abort_flags", {30'd0, ZF, OF}, {30'd0, 1'b1, 1'b0});
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run("add_after_abort", 3'b000, 32'd2, 32'd3, 32'd5, 1'b0, 0, 0);

    // start together with reset must be ignored.
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1; ALU_op = 3'b000; A = 32'd7; B = 32'd8;
    @(posedge clk); #1;
    check("rst_start_done", 32'(done), 32'd0);
    @(negedge clk); rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check("rst_start_idle", {30'd0, done, busy}, 32'd0);

    // Back-to-back ADDs with start held: one done every two cycles.
    begin
      logic [31:0] va[4];
      logic [31:0] vb[4];
      logic [31:0] vf[4];
      logic        vo[4];
      va = '{32'd1, 32'd10, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
      vb = '{32'd2, 32'd20, 32'h7FFF_FFFF, 32'h8000_0000};
      vf = '{32'd3, 32'h1E, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
      vo = '{1'b0, 1'b0, 1'b1, 1'b1};
      @(negedge clk);
      start = 1'b1; ALU_op = 3'b000;
      for (int i = 0; i < 4; i++) begin
        A = va[i]; B = vb[i];
        exp_q.push_back({vf[i], (vf[i] == 32'd0), vo[i]});
        if (i > 0) begin
          @(posedge clk); @(negedge clk);
          check("b2b_gap", 32'(done), 32'd0);
        end
        @(posedge clk); @(negedge clk);
        check("b2b_pulse", 32'(done), 32'd1);
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
    end

    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
